// File: rtl/i2s_rx.sv
// I2S receiver master: generates SCK/WS from clk and captures one SAMPLE_W-bit
// slot per frame from an I2S microphone, with a valid/ready output and sticky overrun.
module i2s_rx #(
  parameter int CLK_DIV  = 16,
  parameter int SAMPLE_W = 24,
  parameter int CHANNEL  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                SD,
  output logic                SCK,
  output logic                WS,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun
);

  localparam int           CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] HALF_TC  = CW'(CLK_DIV - 1);
  localparam logic [4:0]    LAST_BIT = 5'(SAMPLE_W);
  localparam logic          CH_SEL   = 1'(CHANNEL);

  logic [CW-1:0]       half_cnt_r;
  logic                sck_r;
  logic [5:0]          frame_cnt_r;
  logic [SAMPLE_W-1:0] shift_r;
  logic                pend_r;
  logic [SAMPLE_W-1:0] data_r;
  logic                valid_r;
  logic                ovr_r;

  logic                tick_s;
  logic                rise_s;
  logic                fall_s;
  logic [4:0]          bit_idx_s;
  logic                capture_s;

  // Edge events and capture window for the selected slot (b = 0 is the I2S delay bit)
  always_comb begin
    tick_s    = (half_cnt_r == HALF_TC);
    rise_s    = tick_s && !sck_r;
    fall_s    = tick_s && sck_r;
    bit_idx_s = frame_cnt_r[4:0];
    capture_s = 1'b0;
    if (rise_s && (frame_cnt_r[5] == CH_SEL) &&
        (bit_idx_s >= 5'd1) && (bit_idx_s <= LAST_BIT)) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Bit clock divider and frame position
  always_ff @(posedge clk) begin
    if (!reset) begin
      half_cnt_r  <= '0;
      sck_r       <= 1'b0;
      frame_cnt_r <= 6'd0;
    end else begin
      if (tick_s) begin
        half_cnt_r <= '0;
        sck_r      <= ~sck_r;
      end else begin
        half_cnt_r <= half_cnt_r + CW'(1);
      end
      if (fall_s) begin
        frame_cnt_r <= frame_cnt_r + 6'd1;
      end
    end
  end

  // Serial capture; pend_r marks the cycle after the last bit of the slot arrives
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_r <= '0;
      pend_r  <= 1'b0;
    end else begin
      if (capture_s) begin
        shift_r <= (shift_r << 1) | SAMPLE_W'(SD);
      end
      pend_r <= capture_s && (bit_idx_s == LAST_BIT);
    end
  end

  // Output holding register; a load wins over acceptance, overrun only if unaccepted
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      if (pend_r) begin
        data_r  <= shift_r;
        valid_r <= 1'b1;
        if (valid_r && !sample_ready) begin
          ovr_r <= 1'b1;
        end
      end else if (valid_r && sample_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign SCK          = sck_r;
  assign WS           = frame_cnt_r[5];
  assign sample_data  = data_r;
  assign sample_valid = valid_r;
  assign overrun      = ovr_r;

endmodule
